// File: rtl/pio_arb_pkg.sv
// Shared types and helpers for the PIO write arbiter: FSM state encoding,
// the fixed PIO data register address and a constant-foldable clog2.
package pio_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        GAP   = 2'd2
    } arb_state_t;

    localparam logic [1:0] PIO_DATA_ADDR  = 2'd0;
    localparam int         DEFAULT_DATA_W = 32;

    // Number of bits needed to index 'value' distinct items
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin winner selection: searches upward from the slot
// after the previous winner, wrapping modulo NUM_REQ.
module rr_arbiter
    import pio_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any_req
);

    logic found_s;
    logic hit_s;
    int   cand_s;

    // First requester at or after last_grant+1; the previous winner is checked last
    always_comb begin
        found_s   = 1'b0;
        hit_s     = 1'b0;
        cand_s    = 0;
        grant_idx = last_grant;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand_s    = (int'(last_grant) + k) % NUM_REQ;
            hit_s     = !found_s && req[IDX_W'(cand_s)];
            grant_idx = hit_s ? IDX_W'(cand_s) : grant_idx;
            found_s   = found_s | hit_s;
        end
        any_req = found_s;
        grant   = found_s ? (NUM_REQ'(1) << grant_idx) : '0;
    end

endmodule

// File: rtl/pio_write_arbiter.sv
// Shares one Avalon-MM output PIO among NUM_REQ valid/ready requesters with
// round-robin arbitration, one single-cycle write per accepted request.
module pio_write_arbiter
    import pio_arb_pkg::*;
#(
    parameter  int NUM_REQ    = 4,
    parameter  int DATA_W     = DEFAULT_DATA_W,
    parameter  int GAP_CYCLES = 0,
    parameter  int CNT_W      = 16,
    localparam int IDX_W      = clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [1:0]                pio_address,
    output logic                      pio_chipselect,
    output logic                      pio_write_n,
    output logic [DATA_W-1:0]         pio_writedata,
    output logic [DATA_W-1:0]         shadow_value,
    output logic                      busy,
    output logic [IDX_W-1:0]          last_grant,
    output logic [CNT_W-1:0]          write_count
);

    localparam logic [7:0] GAP_LOAD = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

    arb_state_t         state_r;
    logic [DATA_W-1:0]  data_r;
    logic [7:0]         gap_cnt_r;
    logic               chipselect_r;
    logic               write_n_r;
    logic               busy_r;
    logic [DATA_W-1:0]  shadow_r;
    logic [CNT_W-1:0]   count_r;
    logic [IDX_W-1:0]   last_grant_r;

    logic [NUM_REQ-1:0] grant_s;
    logic [IDX_W-1:0]   grant_idx_s;
    logic               any_req_s;
    logic [DATA_W-1:0]  win_data_s;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req        (req_valid),
        .last_grant (last_grant_r),
        .grant      (grant_s),
        .grant_idx  (grant_idx_s),
        .any_req    (any_req_s)
    );

    // Select the winning requester's data word
    always_comb begin
        win_data_s = DATA_W'(req_data >> (int'(grant_idx_s) * DATA_W));
    end

    // Ready is offered only while idle and out of reset
    always_comb begin
        if (reset_n && (state_r == IDLE)) begin
            req_ready = grant_s;
        end else begin
            req_ready = '0;
        end
    end

    // Arbiter FSM; strobes and debug state are registered here
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r      <= IDLE;
            data_r       <= '0;
            gap_cnt_r    <= 8'd0;
            chipselect_r <= 1'b0;
            write_n_r    <= 1'b1;
            busy_r       <= 1'b0;
            shadow_r     <= '0;
            count_r      <= '0;
            last_grant_r <= IDX_W'(NUM_REQ - 1);
        end else begin
            case (state_r)
                IDLE: begin
                    if (any_req_s) begin
                        state_r      <= WRITE;
                        data_r       <= win_data_s;
                        last_grant_r <= grant_idx_s;
                        chipselect_r <= 1'b1;
                        write_n_r    <= 1'b0;
                        busy_r       <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                WRITE: begin
                    chipselect_r <= 1'b0;
                    write_n_r    <= 1'b1;
                    shadow_r     <= data_r;
                    count_r      <= count_r + CNT_W'(1);
                    if (GAP_CYCLES > 0) begin
                        state_r   <= GAP;
                        gap_cnt_r <= GAP_LOAD;
                        busy_r    <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                GAP: begin
                    if (gap_cnt_r == 8'd0) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        gap_cnt_r <= gap_cnt_r - 8'd1;
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    chipselect_r <= 1'b0;
                    write_n_r    <= 1'b1;
                    busy_r       <= 1'b0;
                end
            endcase
        end
    end

    assign pio_address    = PIO_DATA_ADDR;
    assign pio_chipselect = chipselect_r;
    assign pio_write_n    = write_n_r;
    assign pio_writedata  = data_r;
    assign shadow_value   = shadow_r;
    assign busy           = busy_r;
    assign last_grant     = last_grant_r;
    assign write_count    = count_r;

endmodule
